// File: rtl/nx_token_ctrl.sv
// Per-column token controller: grants one token per mesh column, waits for its
// release, re-grants after a gap and flags lost or spurious tokens.
module nx_token_ctrl #(
   parameter int COLUMNS        = 3,
   parameter int GAP_CYCLES     = 1,
   parameter int TIMEOUT_CYCLES = 64,
   parameter int CNT_WIDTH      = 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               enable_i,
   input  logic               clear_i,
   output logic [COLUMNS-1:0] token_grant_o,
   input  logic [COLUMNS-1:0] token_release_i,
   output logic [COLUMNS-1:0] circulating_o,
   output logic [COLUMNS-1:0] timeout_o,
   output logic [COLUMNS-1:0] spurious_o,
   output logic               idle_o
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_GRANT,
      S_WAIT,
      S_GAP
   } state_t;

   localparam logic [CNT_WIDTH-1:0] GAP_LAST     = CNT_WIDTH'(GAP_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE      = CNT_WIDTH'(1);

   state_t               state_q [COLUMNS];
   state_t               state_d [COLUMNS];
   logic [CNT_WIDTH-1:0] cnt_q   [COLUMNS];
   logic [CNT_WIDTH-1:0] cnt_d   [COLUMNS];
   logic [COLUMNS-1:0]   timeout_q, timeout_set;
   logic [COLUMNS-1:0]   spurious_q, spurious_set;
   logic                 idle_q, all_idle;

   // Where a column goes once its token has come back (or been declared lost).
   function automatic state_t lap_next(input logic en);
      if (!en)                  return S_IDLE;
      else if (GAP_CYCLES == 0) return S_GRANT;
      else                      return S_GAP;
   endfunction

   always_comb begin
      // NOTE: every variable gets a default before the case so no path leaves
      // it unassigned, which would otherwise infer a latch.
      all_idle     = 1'b1;
      timeout_set  = '0;
      spurious_set = '0;
      for (int c = 0; c < COLUMNS; c++) begin
         state_d[c] = state_q[c];
         cnt_d[c]   = cnt_q[c];
         all_idle   = all_idle & (state_q[c] == S_IDLE);
         case (state_q[c])
            S_IDLE: begin
               spurious_set[c] = token_release_i[c];
               if (enable_i) state_d[c] = S_GRANT;
            end
            S_GRANT: begin
               cnt_d[c]   = '0;
               state_d[c] = token_release_i[c] ? lap_next(enable_i) : S_WAIT;
            end
            S_WAIT: begin
               cnt_d[c] = cnt_q[c] + CNT_ONE;
               if (token_release_i[c]) begin
                  state_d[c] = lap_next(enable_i);
                  cnt_d[c]   = '0;
               end else if (TIMEOUT_CYCLES > 0 && cnt_q[c] == TIMEOUT_LAST) begin
                  // Lost token: flag it and re-issue as if it had returned.
                  timeout_set[c] = 1'b1;
                  state_d[c]     = lap_next(enable_i);
                  cnt_d[c]       = '0;
               end
            end
            S_GAP: begin
               spurious_set[c] = token_release_i[c];
               cnt_d[c]        = cnt_q[c] + CNT_ONE;
               if (cnt_q[c] == GAP_LAST) begin
                  state_d[c] = enable_i ? S_GRANT : S_IDLE;
                  cnt_d[c]   = '0;
               end
            end
            default: state_d[c] = S_IDLE;
         endcase
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int c = 0; c < COLUMNS; c++) begin
            state_q[c] <= S_IDLE;
            cnt_q[c]   <= '0;
         end
         timeout_q  <= '0;
         spurious_q <= '0;
         idle_q     <= 1'b1;
      end else begin
         for (int c = 0; c < COLUMNS; c++) begin
            state_q[c] <= state_d[c];
            cnt_q[c]   <= cnt_d[c];
         end
         // Set wins over a coincident clear.
         timeout_q  <= (timeout_q  & ~{COLUMNS{clear_i}}) | timeout_set;
         spurious_q <= (spurious_q & ~{COLUMNS{clear_i}}) | spurious_set;
         idle_q     <= all_idle;
      end
   end

   always_comb begin
      token_grant_o = '0;
      circulating_o = '0;
      for (int c = 0; c < COLUMNS; c++) begin
         token_grant_o[c] = (state_q[c] == S_GRANT);
         circulating_o[c] = (state_q[c] == S_GRANT) || (state_q[c] == S_WAIT);
      end
   end

   assign timeout_o  = timeout_q;
   assign spurious_o = spurious_q;
   assign idle_o     = idle_q;

endmodule

// File: tb/tb_nx_token_ctrl.sv
// Bench for nx_token_ctrl: directed vector table, hand-written corner
// sequences and random stimulus against a timestamp-based reference model.
module tb_nx_token_ctrl;

   localparam int NC = 3;
   localparam int NI = 2;
   localparam int GAP_P [NI] = '{1, 0};
   localparam int TO_P  [NI] = '{16, 4};

   logic          clk = 1'b0;
   logic          rst, en, clr;
   logic [NC-1:0] rel;
   logic [NC-1:0] grant_v [NI];
   logic [NC-1:0] circ_v  [NI];
   logic [NC-1:0] to_v    [NI];
   logic [NC-1:0] sp_v    [NI];
   logic          idle_v  [NI];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   nx_token_ctrl #(.COLUMNS(NC), .GAP_CYCLES(1), .TIMEOUT_CYCLES(16), .CNT_WIDTH(8)) dut_a (
      .clk_i(clk), .rst_i(rst), .enable_i(en), .clear_i(clr),
      .token_grant_o(grant_v[0]), .token_release_i(rel),
      .circulating_o(circ_v[0]), .timeout_o(to_v[0]),
      .spurious_o(sp_v[0]), .idle_o(idle_v[0]));

   nx_token_ctrl #(.COLUMNS(NC), .GAP_CYCLES(0), .TIMEOUT_CYCLES(4), .CNT_WIDTH(8)) dut_b (
      .clk_i(clk), .rst_i(rst), .enable_i(en), .clear_i(clr),
      .token_grant_o(grant_v[1]), .token_release_i(rel),
      .circulating_o(circ_v[1]), .timeout_o(to_v[1]),
      .spurious_o(sp_v[1]), .idle_o(idle_v[1]));

   // Reference model: each column is idle, holding a token in the mesh since
   // cycle 'mark', or resting until cycle 'mark' where it decides to re-grant.
   localparam int M_IDLE = 0, M_MESH = 1, M_REST = 2;
   int            now_t;
   int            mode [NI][NC];
   int            mark [NI][NC];
   logic [NC-1:0] m_to [NI];
   logic [NC-1:0] m_sp [NI];
   logic          m_idle [NI];

   function automatic logic [NC-1:0] m_grant(input int m);
      logic [NC-1:0] g = '0;
      for (int c = 0; c < NC; c++) g[c] = (mode[m][c] == M_MESH) && (mark[m][c] == now_t);
      return g;
   endfunction

   function automatic logic [NC-1:0] m_circ(input int m);
      logic [NC-1:0] g = '0;
      for (int c = 0; c < NC; c++) g[c] = (mode[m][c] == M_MESH);
      return g;
   endfunction

   task automatic end_lap(input int m, input int c, input logic e);
      if (!e) mode[m][c] = M_IDLE;
      else if (GAP_P[m] == 0) begin mode[m][c] = M_MESH; mark[m][c] = now_t + 1; end
      else begin mode[m][c] = M_REST; mark[m][c] = now_t + GAP_P[m]; end
   endtask

   task automatic model_step(input logic r, input logic e, input logic cl, input logic [NC-1:0] rl);
      for (int m = 0; m < NI; m++) begin
         logic [NC-1:0] s_to = '0, s_sp = '0;
         logic          all_idle = 1'b1;
         if (r) begin
            for (int c = 0; c < NC; c++) mode[m][c] = M_IDLE;
            m_to[m] = '0; m_sp[m] = '0; m_idle[m] = 1'b1;
            continue;
         end
         for (int c = 0; c < NC; c++) begin
            all_idle &= (mode[m][c] == M_IDLE);
            if (mode[m][c] == M_IDLE) begin
               s_sp[c] = rl[c];
               if (e) begin mode[m][c] = M_MESH; mark[m][c] = now_t + 1; end
            end else if (mode[m][c] == M_MESH) begin
               if (rl[c]) end_lap(m, c, e);
               else if (TO_P[m] > 0 && now_t - mark[m][c] == TO_P[m]) begin
                  s_to[c] = 1'b1;
                  end_lap(m, c, e);
               end
            end else begin
               s_sp[c] = rl[c];
               if (now_t == mark[m][c]) begin
                  if (e) begin mode[m][c] = M_MESH; mark[m][c] = now_t + 1; end
                  else mode[m][c] = M_IDLE;
               end
            end
         end
         m_to[m]   = (cl ? '0 : m_to[m]) | s_to;
         m_sp[m]   = (cl ? '0 : m_sp[m]) | s_sp;
         m_idle[m] = all_idle;
      end
      now_t++;
   endtask

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Called at a falling edge: apply inputs for the coming rising edge.
   task automatic drive(input logic r, input logic e, input logic cl, input logic [NC-1:0] rl);
      rst = r; en = e; clr = cl; rel = rl;
      model_step(r, e, cl, rl);
      @(negedge clk);
   endtask

   task automatic do_reset();
      drive(1'b1, 1'b0, 1'b0, '0);
      drive(1'b1, 1'b0, 1'b0, '0);
   endtask

   typedef struct {
      logic          rst, en, clr;
      logic [NC-1:0] rel;
      logic [NC-1:0] grant, circ, to, sp;
      logic          idle;
   } vec_t;

   vec_t tbl [23];

   function automatic vec_t v(input logic r, input logic e, input logic cl, input logic [2:0] rl,
                              input logic [2:0] g, input logic [2:0] ci, input logic [2:0] t,
                              input logic [2:0] s, input logic id);
      vec_t x;
      x.rst = r; x.en = e; x.clr = cl; x.rel = rl;
      x.grant = g; x.circ = ci; x.to = t; x.sp = s; x.idle = id;
      return x;
   endfunction

   initial begin
      rst = 1'b1; en = 1'b0; clr = 1'b0; rel = '0; now_t = 0;
      for (int m = 0; m < NI; m++) begin
         for (int c = 0; c < NC; c++) begin mode[m][c] = M_IDLE; mark[m][c] = 0; end
         m_to[m] = '0; m_sp[m] = '0; m_idle[m] = 1'b1;
      end

      // Rows are cycles after reset: inputs applied, outputs expected (dut_a, gap 1).
      tbl[0]  = v(1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1);
      tbl[1]  = v(1'b0, 1'b1, 1'b0, 3'b000, 3'b111, 3'b111, 3'b000, 3'b000, 1'b1);
      tbl[2]  = v(1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 1'b0);
      tbl[3]  = v(1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 1'b0);
      tbl[4]  = v(1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 1'b0);
      tbl[5]  = v(1'b0, 1'b1, 1'b0, 3'b010, 3'b000, 3'b111, 3'b000, 3'b000, 1'b0);
      tbl[6]  = v(1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 3'b101, 3'b000, 3'b000, 1'b0);
      tbl[7]  = v(1'b0, 1'b1, 1'b0, 3'b000, 3'b010, 3'b111, 3'b000, 3'b000, 1'b0);
      tbl[8]  = v(1'b0, 1'b1, 1'b0, 3'b101, 3'b000, 3'b111, 3'b000, 3'b000, 1'b0);
      tbl[9]  = v(1'b0, 1'b1, 1'b0, 3'b100, 3'b000, 3'b010, 3'b000, 3'b000, 1'b0);
      tbl[10] = v(1'b0, 1'b1, 1'b1, 3'b000, 3'b101, 3'b111, 3'b000, 3'b100, 1'b0);
      tbl[11] = v(1'b0, 1'b1, 1'b0, 3'b100, 3'b000, 3'b111, 3'b000, 3'b000, 1'b0);
      tbl[12] = v(1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b011, 3'b000, 3'b000, 1'b0);
      tbl[13] = v(1'b0, 1'b0, 1'b0, 3'b001, 3'b000, 3'b011, 3'b000, 3'b000, 1'b0);
      tbl[14] = v(1'b0, 1'b0, 1'b0, 3'b010, 3'b000, 3'b010, 3'b000, 3'b000, 1'b0);
      tbl[15] = v(1'b0, 1'b0, 1'b0, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000, 1'b0);
      tbl[16] = v(1'b0, 1'b0, 1'b1, 3'b100, 3'b000, 3'b000, 3'b000, 3'b100, 1'b1);
      tbl[17] = v(1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100, 1'b1);
      tbl[18] = v(1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1);
      tbl[19] = v(1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1);
      tbl[20] = v(1'b0, 1'b1, 1'b0, 3'b000, 3'b111, 3'b111, 3'b000, 3'b000, 1'b1);
      tbl[21] = v(1'b1, 1'b1, 1'b0, 3'b000, 3'b000, 3'b111, 3'b000, 3'b000, 1'b0);
      tbl[22] = v(1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 1'b1);

      @(negedge clk);
      do_reset();
      for (int k = 0; k < 23; k++) begin
         check($sformatf("tbl%0d grant", k), 8'(grant_v[0]), 8'(tbl[k].grant));
         check($sformatf("tbl%0d circ", k),  8'(circ_v[0]),  8'(tbl[k].circ));
         check($sformatf("tbl%0d timeout", k), 8'(to_v[0]), 8'(tbl[k].to));
         check($sformatf("tbl%0d spurious", k), 8'(sp_v[0]), 8'(tbl[k].sp));
         check($sformatf("tbl%0d idle", k), 8'(idle_v[0]), 8'(tbl[k].idle));
         drive(tbl[k].rst, tbl[k].en, tbl[k].clr, tbl[k].rel);
      end

      // dut_b (gap 0, timeout 4): release at expiry, release in GRANT, timeouts.
      do_reset();
      check("b reset idle", 8'(idle_v[1]), 8'h1);
      drive(1'b0, 1'b1, 1'b0, 3'b000);                          // c0
      check("b c1 grant", 8'(grant_v[1]), 8'h7);
      for (int k = 1; k < 5; k++) drive(1'b0, 1'b1, 1'b0, 3'b000);
      check("b c5 grant", 8'(grant_v[1]), 8'h0);
      drive(1'b0, 1'b1, 1'b0, 3'b111);                          // c5 release at expiry
      check("b c6 grant", 8'(grant_v[1]), 8'h7);
      check("b c6 timeout", 8'(to_v[1]), 8'h0);
      drive(1'b0, 1'b1, 1'b0, 3'b111);                          // c6 release in GRANT
      check("b c7 grant", 8'(grant_v[1]), 8'h7);
      for (int k = 7; k < 11; k++) drive(1'b0, 1'b1, 1'b0, 3'b000);
      check("b c11 timeout", 8'(to_v[1]), 8'h0);
      drive(1'b0, 1'b1, 1'b0, 3'b000);                          // c11 expiry
      check("b c12 timeout", 8'(to_v[1]), 8'h7);
      check("b c12 grant", 8'(grant_v[1]), 8'h7);
      drive(1'b0, 1'b1, 1'b1, 3'b000);                          // c12 clear
      check("b c13 timeout", 8'(to_v[1]), 8'h0);
      for (int k = 13; k < 16; k++) drive(1'b0, 1'b1, 1'b0, 3'b000);
      drive(1'b0, 1'b1, 1'b0, 3'b001);                          // c16 expiry, col0 returns
      check("b c17 grant", 8'(grant_v[1]), 8'h7);
      check("b c17 timeout", 8'(to_v[1]), 8'h6);

      // Random stimulus against the model on both instances.
      do_reset();
      begin
         logic          r_en = 1'b1;
         logic          r_rst, r_clr;
         logic [NC-1:0] r_rel;
         for (int k = 0; k < 3000; k++) begin
            for (int m = 0; m < NI; m++) begin
               check($sformatf("rnd%0d i%0d grant", k, m), 8'(grant_v[m]), 8'(m_grant(m)));
               check($sformatf("rnd%0d i%0d circ", k, m), 8'(circ_v[m]), 8'(m_circ(m)));
               check($sformatf("rnd%0d i%0d timeout", k, m), 8'(to_v[m]), 8'(m_to[m]));
               check($sformatf("rnd%0d i%0d spurious", k, m), 8'(sp_v[m]), 8'(m_sp[m]));
               check($sformatf("rnd%0d i%0d idle", k, m), 8'(idle_v[m]), 8'(m_idle[m]));
            end
            if ($urandom_range(39) == 0) r_en = ~r_en;
            r_rst = ($urandom_range(399) == 0);
            r_clr = ($urandom_range(29) == 0);
            for (int c = 0; c < NC; c++) r_rel[c] = ($urandom_range(7) == 0);
            drive(r_rst, r_en, r_clr, r_rel);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
